// File: rtl/round_sequencer.sv
// round_sequencer: round flow controller for the pattern-memory game.
// Define ROUND_TIMEOUT_EN to enable the input-phase timeout.
module round_sequencer #(
  parameter int NUM_ROUNDS  = 10,
  parameter int MAX_LEN     = 16,
  parameter int SYM_W       = 3,
  parameter int LEN_L1      = 8,
  parameter int LEN_L2      = 12,
  parameter int LEN_L3      = 16,
  parameter int GAP_CYC     = 500,
  parameter int POINTS      = 10,
  parameter int SCORE_W     = 7,
  parameter int TIMEOUT_CYC = 5000,
  localparam int CW = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                     clk_1,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               level,
  input  logic [MAX_LEN*SYM_W-1:0] pattern,
  input  logic [MAX_LEN*SYM_W-1:0] user_inp,
  input  logic                     gen_done,
  input  logic                     show_done,
  input  logic                     inp_done,
  output logic                     gen_start,
  output logic                     show_start,
  output logic                     inp_start,
  output logic                     sub_clr_n,
  output logic                     round_win,
  output logic                     round_timeout,
  output logic [CW-1:0]            round_cnt,
  output logic [CW-1:0]            correct_cnt,
  output logic [SCORE_W-1:0]       score,
  output logic                     game_end,
  output logic                     busy
);

  localparam int MAXC = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int TW   = $clog2(MAXC + 1);
  localparam int SMAX = 2**SCORE_W - 1;

  // LAUNCH is the one-cycle sub-block clear between start and GEN
  typedef enum logic [2:0] {
    IDLE, LAUNCH, GEN, SHOW, INPUT, CHECK, GAP, DONE
  } state_t;

  state_t state, next;
  logic [2:0]         len_sel, len_sel_d;
  logic [TW-1:0]      cnt;
  logic               go, win, timeout, entry;
  logic [31:0]        prod;
  logic               gen_start_d, show_start_d, inp_start_d;
  logic               sub_clr_n_d, round_win_d, round_timeout_d;
  logic [CW-1:0]      round_cnt_d, correct_cnt_d;
  logic [SCORE_W-1:0] score_d;
  logic               game_end_d, busy_d;
  int                 lim;

  assign go = start &&
    (level == 3'b001 || level == 3'b010 || level == 3'b100);
  assign entry = (next != state);
  assign prod = 32'(POINTS) * 32'(correct_cnt);

`ifdef ROUND_TIMEOUT_EN
  assign timeout = (state == INPUT) &&
    (cnt == TW'(TIMEOUT_CYC - 1)) && !(inp_done && !inp_start);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    lim = LEN_L1;
    unique case (1'b1)
      len_sel[0]: lim = LEN_L1;
      len_sel[1]: lim = LEN_L2;
      len_sel[2]: lim = LEN_L3;
      default:    lim = LEN_L1;
    endcase
    win = 1'b1;
    for (int i = 0; i < MAX_LEN; i++)
      if (i < lim &&
          pattern[i*SYM_W +: SYM_W] != user_inp[i*SYM_W +: SYM_W])
        win = 1'b0;
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      len_sel       <= '0;
      gen_start     <= 1'b0;
      show_start    <= 1'b0;
      inp_start     <= 1'b0;
      sub_clr_n     <= 1'b1;
      round_win     <= 1'b0;
      round_timeout <= 1'b0;
      round_cnt     <= '0;
      correct_cnt   <= '0;
      score         <= '0;
      game_end      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= next;
      cnt           <= entry ? '0 : cnt + 1'b1;
      len_sel       <= len_sel_d;
      gen_start     <= gen_start_d;
      show_start    <= show_start_d;
      inp_start     <= inp_start_d;
      sub_clr_n     <= sub_clr_n_d;
      round_win     <= round_win_d;
      round_timeout <= round_timeout_d;
      round_cnt     <= round_cnt_d;
      correct_cnt   <= correct_cnt_d;
      score         <= score_d;
      game_end      <= game_end_d;
      busy          <= busy_d;
    end
  end

  // done inputs are masked while the matching start pulse is high
  always_comb begin
    next = state;
    unique case (state)
      IDLE, DONE: if (go) next = LAUNCH;
      LAUNCH:     next = GEN;
      GEN:        if (gen_done && !gen_start) next = SHOW;
      SHOW:       if (show_done && !show_start) next = INPUT;
      INPUT: begin
        if (inp_done && !inp_start) next = CHECK;
        else if (timeout)           next = GAP;
      end
      CHECK:      next = GAP;
      GAP: begin
        if (cnt == TW'(GAP_CYC - 1))
          next = (round_cnt < CW'(NUM_ROUNDS)) ? GEN : DONE;
      end
      default:    next = IDLE;
    endcase
  end

  always_comb begin
    gen_start_d     = entry && next == GEN;
    show_start_d    = entry && next == SHOW;
    inp_start_d     = entry && next == INPUT;
    sub_clr_n_d     = !(entry && (next == LAUNCH || next == GAP));
    round_win_d     = (state == CHECK) && win;
    round_timeout_d = timeout;
    game_end_d      = (next == DONE);
    busy_d          = !(next == IDLE || next == DONE);
    len_sel_d       = len_sel;
    round_cnt_d     = round_cnt;
    correct_cnt_d   = correct_cnt;
    score_d         = score;
    if (next == LAUNCH) begin
      len_sel_d     = level;
      round_cnt_d   = '0;
      correct_cnt_d = '0;
      score_d       = '0;
    end else begin
      if (state == CHECK || timeout)
        round_cnt_d = round_cnt + 1'b1;
      if (state == CHECK && win)
        correct_cnt_d = correct_cnt + 1'b1;
      if (entry && next == DONE)
        score_d = (prod > 32'(SMAX)) ? SCORE_W'(SMAX)
                                     : prod[SCORE_W-1:0];
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed checks of round_sequencer game flow.
// Second instance with POINTS=20 checks score saturation.
module tb_round_sequencer;

  localparam int ML = 16;
  localparam int SW = 3;
  localparam int GAP = 500;
  localparam logic [ML*SW-1:0] HI8 = {24'hFFFFFF, 24'h000000};

  logic          clk_1 = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    level = 3'b000;
  logic [ML*SW-1:0] pattern = '0;
  logic [ML*SW-1:0] user_inp = '0;
  logic          gen_done = 1'b0;
  logic          show_done = 1'b0;
  logic          inp_done = 1'b0;

  logic gen_start, show_start, inp_start, sub_clr_n;
  logic round_win, round_timeout, game_end, busy;
  logic [3:0] round_cnt, correct_cnt;
  logic [6:0] score;

  logic s_gen_start, s_show_start, s_inp_start, s_sub_clr_n;
  logic s_round_win, s_round_timeout, s_game_end, s_busy;
  logic [3:0] s_round_cnt, s_correct_cnt;
  logic [6:0] s_score;

  int tests = 0;
  int fails = 0;

  always #5 clk_1 = ~clk_1;

  round_sequencer u_dut (
    .clk_1(clk_1), .rst(rst), .start(start), .level(level),
    .pattern(pattern), .user_inp(user_inp),
    .gen_done(gen_done), .show_done(show_done), .inp_done(inp_done),
    .gen_start(gen_start), .show_start(show_start),
    .inp_start(inp_start), .sub_clr_n(sub_clr_n),
    .round_win(round_win), .round_timeout(round_timeout),
    .round_cnt(round_cnt), .correct_cnt(correct_cnt),
    .score(score), .game_end(game_end), .busy(busy)
  );

  round_sequencer #(.POINTS(20)) u_sat (
    .clk_1(clk_1), .rst(rst), .start(start), .level(level),
    .pattern(pattern), .user_inp(user_inp),
    .gen_done(gen_done), .show_done(show_done), .inp_done(inp_done),
    .gen_start(s_gen_start), .show_start(s_show_start),
    .inp_start(s_inp_start), .sub_clr_n(s_sub_clr_n),
    .round_win(s_round_win), .round_timeout(s_round_timeout),
    .round_cnt(s_round_cnt), .correct_cnt(s_correct_cnt),
    .score(s_score), .game_end(s_game_end), .busy(s_busy)
  );

  task automatic wait_out(input int sel, input int lim, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < lim) begin
      case (sel)
        0:       hit = gen_start;
        1:       hit = show_start;
        2:       hit = inp_start;
        default: hit = game_end;
      endcase
      if (!hit) begin
        @(negedge clk_1);
        n++;
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL wait_%0d: no event after %0d cycles", sel, lim);
    end
  endtask

  task automatic start_game(input logic [2:0] lv);
    @(negedge clk_1);
    start = 1'b1;
    level = lv;
    @(negedge clk_1);
    start = 1'b0;
    tests++;
    if (sub_clr_n !== 1'b0 || busy !== 1'b1 || gen_start !== 1'b0 ||
        game_end !== 1'b0 || score !== 7'd0 ||
        round_cnt !== 4'd0 || correct_cnt !== 4'd0) begin
      fails++;
      $display("FAIL launch: clr=%b busy=%b gs=%b end=%b sc=%0d rc=%0d cc=%0d, want 0 1 0 0 0 0 0",
               sub_clr_n, busy, gen_start, game_end, score,
               round_cnt, correct_cnt);
    end
    @(negedge clk_1);
    tests++;
    if (gen_start !== 1'b1) begin
      fails++;
      $display("FAIL start_latency: gen_start=%b want 1", gen_start);
    end
  endtask

  task automatic play_round(input logic [ML*SW-1:0] p,
                            input logic [ML*SW-1:0] u,
                            input logic w,
                            input logic [3:0] rc,
                            input logic [3:0] cc,
                            input bit poke);
    int n;
    wait_out(0, 1000, n);
    gen_done = 1'b1;
    wait_out(1, 20, n);
    if (poke) begin
      start = 1'b1;
      level = 3'b001;
      repeat (2) @(negedge clk_1);
      start = 1'b0;
      level = 3'b010;
      tests++;
      if (sub_clr_n !== 1'b1 || busy !== 1'b1) begin
        fails++;
        $display("FAIL start_in_show: clr=%b busy=%b want 1 1",
                 sub_clr_n, busy);
      end
    end
    show_done = 1'b1;
    wait_out(2, 20, n);
    pattern = p;
    user_inp = u;
    @(negedge clk_1);
    inp_done = 1'b1;
    @(negedge clk_1);
    tests++;
    if (round_win !== 1'b0) begin
      fails++;
      $display("FAIL win_early: round_win=%b want 0", round_win);
    end
    @(negedge clk_1);
    tests++;
    if (round_win !== w) begin
      fails++;
      $display("FAIL round_win: got %b want %b", round_win, w);
    end
    tests++;
    if (round_cnt !== rc || correct_cnt !== cc) begin
      fails++;
      $display("FAIL counts: rc=%0d cc=%0d want %0d %0d",
               round_cnt, correct_cnt, rc, cc);
    end
    tests++;
    if (sub_clr_n !== 1'b0) begin
      fails++;
      $display("FAIL gap_clear: sub_clr_n=%b want 0", sub_clr_n);
    end
    gen_done = 1'b0;
    show_done = 1'b0;
    inp_done = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk_1);
    tests++;
    if (gen_start !== 1'b0 || show_start !== 1'b0 || inp_start !== 1'b0 ||
        round_win !== 1'b0 || round_timeout !== 1'b0 ||
        sub_clr_n !== 1'b1 || round_cnt !== 4'd0 ||
        correct_cnt !== 4'd0 || score !== 7'd0 ||
        game_end !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset: gs=%b ss=%b is=%b w=%b to=%b clr=%b rc=%0d cc=%0d sc=%0d end=%b busy=%b",
               gen_start, show_start, inp_start, round_win,
               round_timeout, sub_clr_n, round_cnt, correct_cnt,
               score, game_end, busy);
    end
    rst = 1'b1;
  endtask

  task automatic test_full_game;
    logic [ML*SW-1:0] p;
    int n;
    start_game(3'b001);
    for (int k = 1; k <= 10; k++) begin
      p = {24'($urandom), 24'($urandom)};
      play_round(p, p ^ HI8, 1'b1, 4'(k), 4'(k), 1'b0);
      if (k == 1) begin
        wait_out(0, 1000, n);
        tests++;
        if (n != GAP) begin
          fails++;
          $display("FAIL gap_len: %0d cycles want %0d", n, GAP);
        end
      end
    end
    wait_out(3, 1000, n);
    tests++;
    if (n != GAP) begin
      fails++;
      $display("FAIL done_gap: %0d cycles want %0d", n, GAP);
    end
    tests++;
    if (correct_cnt !== 4'd10 || round_cnt !== 4'd10 ||
        score !== 7'd100 || busy !== 1'b0) begin
      fails++;
      $display("FAIL final: cc=%0d rc=%0d sc=%0d busy=%b want 10 10 100 0",
               correct_cnt, round_cnt, score, busy);
    end
    tests++;
    if (s_score !== 7'd127 || s_game_end !== 1'b1) begin
      fails++;
      $display("FAIL saturate: score=%0d end=%b want 127 1",
               s_score, s_game_end);
    end
    repeat (3) @(negedge clk_1);
    tests++;
    if (game_end !== 1'b1 || score !== 7'd100) begin
      fails++;
      $display("FAIL done_hold: end=%b sc=%0d want 1 100",
               game_end, score);
    end
  endtask

  task automatic test_level2;
    logic [ML*SW-1:0] p;
    p = 48'h0123_4567_89AB;
    start_game(3'b010);
    play_round(p, p ^ (48'h7 << 36), 1'b1, 4'd1, 4'd1, 1'b0);
    play_round(p, p ^ (48'h7 << 33), 1'b0, 4'd2, 4'd1, 1'b1);
    play_round(p, p ^ (48'h5 << 45), 1'b1, 4'd3, 4'd2, 1'b0);
  endtask

  task automatic test_async_reset;
    int n;
    wait_out(0, 1000, n);
    gen_done = 1'b1;
    wait_out(1, 20, n);
    show_done = 1'b1;
    wait_out(2, 20, n);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || round_cnt !== 4'd0 || correct_cnt !== 4'd0 ||
        inp_start !== 1'b0 || sub_clr_n !== 1'b1) begin
      fails++;
      $display("FAIL async_rst: busy=%b rc=%0d cc=%0d is=%b clr=%b",
               busy, round_cnt, correct_cnt, inp_start, sub_clr_n);
    end
    gen_done = 1'b0;
    show_done = 1'b0;
    inp_done = 1'b0;
    repeat (2) @(negedge clk_1);
    rst = 1'b1;
    repeat (2) @(negedge clk_1);
    tests++;
    if (busy !== 1'b0 || gen_start !== 1'b0) begin
      fails++;
      $display("FAIL post_rst: busy=%b gs=%b want 0 0", busy, gen_start);
    end
  endtask

  task automatic test_bad_level;
    logic [2:0] lv [2];
    lv[0] = 3'b011;
    lv[1] = 3'b000;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk_1);
      start = 1'b1;
      level = lv[j];
      for (int c = 0; c < 4; c++) begin
        @(negedge clk_1);
        tests++;
        if (gen_start !== 1'b0 || busy !== 1'b0 || sub_clr_n !== 1'b1) begin
          fails++;
          $display("FAIL bad_level %b: gs=%b busy=%b clr=%b",
                   lv[j], gen_start, busy, sub_clr_n);
        end
      end
      start = 1'b0;
    end
  endtask

  initial begin
    test_reset;
    test_full_game;
    test_level2;
    test_async_reset;
    test_bad_level;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
